fetch_predict_stage: RTL

Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of decode and the hazard detection logic.
- Holds the PC and drives the instruction-memory address.
- Predicts branches with a direct-mapped table of 2-bit counters plus a branch target buffer (BTB).
- Obeys PC_stall, IF_ID_stall, IF_flush and update_PC from the hazard unit.
- Trains its predictor from branch resolution in ID.

---
 rtl/fetch_predict_stage_pkg.sv | 26 ++
 rtl/branch_predictor_table.sv | 57 +++++
 rtl/fetch_predict_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/fetch_predict_stage_pkg.sv
// Shared constants, counter encoding and saturating counter update for the fetch stage.
package fetch_predict_stage_pkg;

  localparam int          PC_W      = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [3:0]  OPC_HLT   = 4'hF;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != ST) r = ctr_t'(c + 2'd1);
    end else begin
      if (c != SNT) r = ctr_t'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// Direct-mapped 2-bit counter table plus BTB; combinational lookup, clocked training.
module branch_predictor_table
  import fetch_predict_stage_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:1]   lookup_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              train_en,
  input  logic              train_taken,
  input  logic [PC_W-1:1]   train_pc,
  input  logic [PC_W-1:0]   train_target
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 1;

  ctr_t              ctr    [N];
  logic              valid  [N];
  logic [TAG_W-1:0]  tag    [N];
  logic [PC_W-1:0]   target [N];

  logic [IDX_W-1:0]  ri, wi;
  logic [TAG_W-1:0]  rtag, wtag;

  assign ri   = lookup_pc[IDX_W:1];
  assign rtag = lookup_pc[PC_W-1:IDX_W+1];
  assign wi   = train_pc[IDX_W:1];
  assign wtag = train_pc[PC_W-1:IDX_W+1];

  // Reads see pre-training state; a same-index write lands next cycle.
  assign pred_taken  = ctr[ri][1] & valid[ri] & (tag[ri] == rtag);
  assign pred_target = target[ri];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        ctr[k]    <= WNT;
        valid[k]  <= 1'b0;
        tag[k]    <= '0;
        target[k] <= '0;
      end
    end else if (train_en) begin
      ctr[wi] <= ctr_next(ctr[wi], train_taken);
      // Not-taken outcomes leave the BTB entry in place.
      if (train_taken) begin
        valid[wi]  <= 1'b1;
        tag[wi]    <= wtag;
        target[wi] <= train_target;
      end
    end
  end

endmodule

// File: rtl/fetch_predict_stage.sv
// Fetch stage: PC, next-PC selection, halt tracking and IF/ID pipeline register.
module fetch_predict_stage
  import fetch_predict_stage_pkg::*;
#(
  parameter int          BHT_IDX_W = 3,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_stall,
  input  logic        IF_ID_stall,
  input  logic        IF_flush,
  input  logic        update_PC,
  input  logic [15:0] actual_target,
  input  logic        ID_Branch,
  input  logic        ID_taken,
  input  logic [15:0] ID_PC,
  input  logic [15:0] ID_target,
  output logic [15:0] instr_addr,
  input  logic [15:0] instr_data,
  output logic [15:0] PC_curr,
  output logic [15:0] IF_ID_instr,
  output logic [15:0] IF_ID_PC_plus2,
  output logic        IF_ID_pred_taken,
  output logic [15:0] IF_ID_pred_target,
  output logic        halted
);

  logic [PC_W-1:0] pc, pc_plus2, pc_next, pred_target;
  logic            pred_taken, hold_halt, halt_next, train_en;
  logic            unused;

  assign pc_plus2   = pc + 16'd2;
  assign instr_addr = pc;
  assign PC_curr    = pc;
  assign train_en   = ID_Branch & ~IF_ID_stall;
  assign hold_halt  = halted | ((instr_data[15:12] == OPC_HLT) & ~IF_flush);
  assign unused     = ID_PC[0];

  branch_predictor_table #(.IDX_W(BHT_IDX_W)) u_bpt (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_pc    (pc[PC_W-1:1]),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .train_en     (train_en),
    .train_taken  (ID_taken),
    .train_pc     (ID_PC[PC_W-1:1]),
    .train_target (ID_target)
  );

  always_comb begin
    pc_next   = pc;
    halt_next = halted;
    if (!PC_stall) begin
      if (update_PC) begin
        pc_next   = actual_target;
        halt_next = 1'b0;
      end else if (hold_halt) begin
        halt_next = 1'b1;
      end else if (pred_taken) begin
        pc_next = pred_target;
      end else begin
        pc_next = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      pc     <= pc_next;
      halted <= halt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_instr       <= NOP_INSTR;
      IF_ID_PC_plus2    <= '0;
      IF_ID_pred_taken  <= 1'b0;
      IF_ID_pred_target <= '0;
    end else if (!IF_ID_stall) begin
      if (IF_flush) begin
        IF_ID_instr       <= NOP_INSTR;
        IF_ID_PC_plus2    <= '0;
        IF_ID_pred_taken  <= 1'b0;
        IF_ID_pred_target <= '0;
      end else begin
        IF_ID_instr       <= instr_data;
        IF_ID_PC_plus2    <= pc_plus2;
        IF_ID_pred_taken  <= pred_taken;
        IF_ID_pred_target <= pred_target;
      end
    end
  end

endmodule
